// File: rtl/operand_loader.sv
// rtl/operand_loader.sv - collects two N-bit operands byte-by-byte and presents them as a held pair
module operand_loader #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         flush,
  output logic [N-1:0] a,
  output logic [N-1:0] b,
  output logic         op_valid,
  input  logic         op_ready,
  output logic         loaded_a
);

  localparam int NB = N / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NB - 1);

  typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, PRESENT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          accept;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      a        <= '0;
      b        <= '0;
      op_valid <= 1'b0;
      in_ready <= 1'b0;
      loaded_a <= 1'b0;
    end else if (state == IDLE) begin
      state    <= LOAD_A;
      in_ready <= 1'b1;
    end else if (flush) begin
      // Flush wins over any byte accept or pair handshake on this edge.
      state    <= LOAD_A;
      cnt      <= '0;
      a        <= '0;
      b        <= '0;
      op_valid <= 1'b0;
      in_ready <= 1'b1;
      loaded_a <= 1'b0;
    end else begin
      case (state)
        LOAD_A: if (accept) begin
          for (int i = 0; i < NB; i++)
            if (cnt == CW'(i)) a[8*i +: 8] <= in_data;
          if (cnt == CNT_LAST) begin
            cnt      <= '0;
            state    <= LOAD_B;
            loaded_a <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LOAD_B: if (accept) begin
          for (int i = 0; i < NB; i++)
            if (cnt == CW'(i)) b[8*i +: 8] <= in_data;
          if (cnt == CNT_LAST) begin
            cnt      <= '0;
            state    <= PRESENT;
            in_ready <= 1'b0;
            op_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESENT: if (op_ready) begin
          a        <= '0;
          b        <= '0;
          state    <= LOAD_A;
          op_valid <= 1'b0;
          in_ready <= 1'b1;
          loaded_a <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/operand_loader.md
# operand_loader

Upstream feeder for the N-bit combinational adder stage (`{cout,sum} = a+b`). It collects both N-bit operands byte-by-byte from an 8-bit valid/ready stream. It presents them together as a registered pair with a valid/ready handshake, and holds them stable until the adder-side consumer accepts them. This lets a narrow bus (UART/switch bank/testbench driver) drive the 32-bit datapath.

## Interface
Parameters:
- N, 32, operand width in bits; N must be a multiple of 8 and ≥ 8. NB = N/8 bytes per operand.

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_data  input  8  operand byte, little-endian within each operand
- in_valid  input  1  in_data is valid
- in_ready  output  1  loader can accept a byte this cycle
- flush  input  1  synchronous abort; discards any partial or presented pair
- a  output  N  operand A to the adder
- b  output  N  operand B to the adder
- op_valid  output  1  a and b form a complete, stable pair
- op_ready  input  1  consumer accepts the pair this cycle
- loaded_a  output  1  high when all NB bytes of A are captured (status)

## Operation
- States: IDLE, LOAD_A, LOAD_B, PRESENT. A byte counter `cnt` ranges from 0 to NB-1.
- Byte accept = in_valid && in_ready at a rising edge.
- IDLE: entered only from reset. Moves to LOAD_A unconditionally on the first edge after rst deasserts.
- LOAD_A: each accept writes in_data to a[8*cnt+7 : 8*cnt] and increments cnt. An accept with cnt==NB-1 sets cnt=0 and moves to LOAD_B.
- LOAD_B: same as LOAD_A but writes b. An accept with cnt==NB-1 sets cnt=0 and moves to PRESENT.
- PRESENT: op_valid=1; a and b are held constant. When op_valid && op_ready: clear a and b to 0 and move to LOAD_A.
- in_ready = 1 in LOAD_A/LOAD_B, 0 in IDLE/PRESENT. It is a registered output.
- loaded_a = 1 in LOAD_B and PRESENT, else 0.
- flush at an edge in any non-IDLE state:
  - a=0, b=0, cnt=0, state=LOAD_A, op_valid=0.
  - flush has priority over a simultaneous byte accept (the byte is dropped) and over a simultaneous op handshake (the pair is treated as not consumed).
- in_valid while in_ready=0 is ignored; no byte is lost from the loader's point of view, because the producer must hold it.
- Bytes not yet written in the current operand read as 0.
- NB==1 (N=8): each operand is loaded in a single accept.

## Timing
- Reset values: a=0, b=0, op_valid=0, in_ready=0, loaded_a=0, cnt=0, state=IDLE.
- After rst falls: in_ready=1 from the first rising edge onward.
- Each byte costs 1 cycle at full throughput. in_ready stays high from the first byte of A through the last byte of B, with no bubble between the A→B transition.
- op_valid rises the cycle after the last B byte is accepted; in_ready falls in that same cycle. Minimum latency from first byte to op_valid is 2·NB cycles.
- op_valid stays high, with a and b unchanged, for as long as op_ready=0.
- The cycle after the handshake: op_valid=0, in_ready=1, a=b=0. With continuous traffic, minimum pair period is 2·NB+1 cycles.
- op_ready has no effect when op_valid=0.
- Asynchronous rst mid-load or mid-present: all outputs go immediately to their reset values, and the partial pair is lost.

## Test plan
- Basic load (N=32): bytes 78,56,34,12 then FF,FF,FF,FF with in_valid held high → op_valid rises 8 cycles after the first accept, a=0x12345678, b=0xFFFFFFFF, in_ready=0 while presenting.
- Backpressure: hold op_ready=0 for 5 cycles after op_valid → a and b remain stable, in_ready stays 0, and extra in_valid bytes are not accepted. Pulse op_ready → the next cycle has op_valid=0, a=b=0, in_ready=1.
- Gapped input: insert in_valid=0 bubbles between bytes, then load A=0x000000AA, B=0x00000001 → cnt advances only on accepts, and the same pair is presented. loaded_a rises after the 4th accept.
- Flush priority: assert flush together with the 3rd byte of B; separately, assert flush together with op_ready in PRESENT → in both cases state=LOAD_A, a=b=0, and op_valid=0 the next cycle. No pair is counted as consumed.
- Async reset mid-load: assert rst between clock edges after 5 accepts → outputs reach reset values without a clock edge. A full reload afterwards yields the correct pair.
- N=8 instance: bytes 0x80,0x80 → op_valid with a=0x80, b=0x80 two cycles after the first accept; back-to-back pairs alternate correctly.
